spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_pkg.sv | 21 ++
 rtl/spi_slave.sv | 123 ++++++++++++
 tb/tb_spi_slave.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave front end of the SPI-RAM path.
package spi_slave_pkg;

  localparam int unsigned RX_W = 10;
  localparam int unsigned TX_W = 8;

  // Command codes carried in rx_data[9:8].
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

endpackage

// File: rtl/spi_slave.sv
// SPI slave: deserialises 10-bit command words and serialises read data on MISO.
// Optional abort strobe on SS_n deassertion outside IDLE: define SPI_SLAVE_ABORT_FLAG_EN.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = TX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
`ifdef SPI_SLAVE_ABORT_FLAG_EN
  ,
  output logic                 abort
`endif
);

  localparam int unsigned RXW     = ADDR_SIZE + 2;
  localparam logic [3:0]  RX_LAST = 4'(ADDR_SIZE);
  localparam logic [3:0]  TX_LAST = 4'(ADDR_SIZE - 1);

  state_t               state;
  logic [3:0]           cnt;
  logic [RXW-2:0]       rx_shift;
  logic [ADDR_SIZE-1:0] tx_shift;
  logic                 frame_done;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 rd_addr_flag;

  // Single registered FSM; SS_n high outside IDLE takes priority over any frame progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      frame_done   <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
      rd_addr_flag <= 1'b0;
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
      abort        <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
      abort    <= 1'b0;
`endif
      if (state != IDLE && SS_n) begin
        state      <= IDLE;
        cnt        <= 4'd0;
        frame_done <= 1'b0;
        tx_busy    <= 1'b0;
        tx_done    <= 1'b0;
        MISO       <= 1'b0;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
        abort      <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: begin
            cnt <= 4'd0;
            if (!SS_n) state <= CHK_CMD;
          end
          CHK_CMD: begin
            rx_shift   <= {rx_shift[RXW-3:0], MOSI};
            cnt        <= 4'd0;
            frame_done <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            if (!MOSI)             state <= WRITE;
            else if (rd_addr_flag) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!frame_done) begin
              rx_shift <= {rx_shift[RXW-3:0], MOSI};
              if (cnt == RX_LAST) begin
                frame_done <= 1'b1;
                cnt        <= 4'd0;
                rx_valid   <= 1'b1;
                rx_data    <= {rx_shift, MOSI};
                if (state == READ_ADD) rd_addr_flag <= 1'b1;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end else if (state == READ_DATA) begin
              // Counter is reused as the MISO bit index once the command word is in.
              if (tx_busy) begin
                if (cnt == TX_LAST) begin
                  MISO         <= 1'b0;
                  tx_busy      <= 1'b0;
                  tx_done      <= 1'b1;
                  rd_addr_flag <= 1'b0;
                end else begin
                  MISO     <= tx_shift[ADDR_SIZE-1];
                  tx_shift <= {tx_shift[ADDR_SIZE-2:0], 1'b0};
                  cnt      <= cnt + 4'd1;
                end
              end else if (!tx_done && tx_valid) begin
                MISO     <= tx_data[ADDR_SIZE-1];
                tx_shift <= {tx_data[ADDR_SIZE-2:0], 1'b0};
                tx_busy  <= 1'b1;
                cnt      <= 4'd0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: stimulus queues expectations, a negedge monitor checks them.
module tb_spi_slave;
  import spi_slave_pkg::*;

  localparam int P_MISO  = 0;
  localparam int P_RXV   = 1;
  localparam int P_FLAG  = 2;
  localparam int P_STATE = 3;
  localparam int P_RXD   = 4;
  localparam int P_ABORT = 5;
  localparam int P_END   = 6;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } probe_t;

  logic       clk;
  logic       rst_n;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
  logic       abort;
`endif

  logic [9:0] rx_q[$];
  probe_t     probe_q[$];
  int         checks   = 0;
  int         failures = 0;

  spi_slave #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    ,
    .abort    (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every rx_valid pops the rx scoreboard; queued probes are checked mid-cycle.
  probe_t      p;
  logic [31:0] got;
  logic [9:0]  exp_rx;
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      checks++;
      if (rx_q.size() == 0) begin
        failures++;
        $display("FAIL rx_unexpected: got rx_data=%h, required no rx_valid", rx_data);
      end else begin
        exp_rx = rx_q.pop_front();
        if (rx_data !== exp_rx) begin
          failures++;
          $display("FAIL rx_data: got %h, required %h", rx_data, exp_rx);
        end
      end
    end
    while (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      if (p.kind == P_END) begin
        checks++;
        if (rx_q.size() != 0) begin
          failures++;
          $display("FAIL rx_pending: got %0d outstanding words, required 0", rx_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
      case (p.kind)
        P_MISO:  got = 32'(MISO);
        P_RXV:   got = 32'(rx_valid);
        P_FLAG:  got = 32'(dut.rd_addr_flag);
        P_STATE: got = 32'(dut.state);
        P_RXD:   got = 32'(rx_data);
`ifdef SPI_SLAVE_ABORT_FLAG_EN
        P_ABORT: got = 32'(abort);
`endif
        default: got = 32'hDEAD_BEEF;
      endcase
      checks++;
      if (got !== p.exp) begin
        failures++;
        $display("FAIL %s: got %h, required %h", p.name, got, p.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int kind, input logic [31:0] exp, input string name);
    probe_t q;
    q.kind = kind;
    q.exp  = exp;
    q.name = name;
    probe_q.push_back(q);
  endtask

  // Full frame; returns just after the edge that samples bit 0.
  task automatic send_frame(input logic [9:0] w);
    SS_n = 1'b0;
    MOSI = w[9];
    tick();
    for (int i = 9; i >= 0; i--) begin
      MOSI = w[i];
      if (i == 0) rx_q.push_back(w);
      tick();
    end
    probe(P_RXV, 32'd1, "rx_valid_on");
  endtask

  // Frame cut short: nbits data edges, then SS_n high on the next edge.
  task automatic abort_frame(input logic [9:0] w, input int nbits);
    SS_n = 1'b0;
    tick();
    for (int k = 0; k < nbits; k++) begin
      MOSI = w[9-k];
      tick();
    end
    MOSI = w[9-nbits];
    SS_n = 1'b1;
    tick();
    probe(P_STATE, 32'(IDLE), "abort_state");
    probe(P_RXV, 32'd0, "abort_rx_valid");
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    probe(P_ABORT, 32'd1, "abort_pulse");
`endif
    tick();
    probe(P_RXV, 32'd0, "abort_rx_valid_after");
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    probe(P_ABORT, 32'd0, "abort_pulse_end");
`endif
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    tick();
    probe(P_STATE, 32'(IDLE), "frame_end_idle");
  endtask

  logic [7:0] txv;

  initial begin
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    tick();
    tick();
    probe(P_MISO, 32'd0, "reset_miso");
    probe(P_RXV, 32'd0, "reset_rx_valid");
    probe(P_RXD, 32'd0, "reset_rx_data");
    probe(P_FLAG, 32'd0, "reset_flag");
    probe(P_STATE, 32'(IDLE), "reset_state");
    rst_n = 1'b1;

    // Write address, then extra bits that must be ignored.
    send_frame(10'h005);
    tick();
    probe(P_RXV, 32'd0, "wr_addr_strobe_one_cycle");
    probe(P_FLAG, 32'd0, "wr_addr_flag");
    for (int i = 0; i < 3; i++) begin
      MOSI = ~MOSI;
      tick();
    end
    end_frame();

    // Write data with a stray tx_valid held high.
    tx_valid = 1'b1; tx_data = 8'hFF;
    send_frame(10'h1A5);
    probe(P_MISO, 32'd0, "wr_data_miso_idle");
    tick();
    probe(P_MISO, 32'd0, "wr_data_miso_ignores_tx");
    tx_valid = 1'b0;
    end_frame();

    send_frame(10'h205);
    tick();
    probe(P_FLAG, 32'd1, "rd_addr_flag_set");
    end_frame();

    abort_frame(10'h3FF, 6);
    probe(P_FLAG, 32'd1, "abort_keeps_flag");

    // Read data with tx_valid one cycle after rx_valid.
    send_frame(10'h3F0);
    MOSI = 1'b1;
    tick();
    probe(P_RXV, 32'd0, "rd_data_strobe_one_cycle");
    probe(P_MISO, 32'd0, "rd_data_miso_wait");
    txv = 8'hA5;
    tx_valid = 1'b1; tx_data = txv;
    tick();
    tx_valid = 1'b0; tx_data = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      probe(P_MISO, 32'(txv[i]), $sformatf("miso_a5_bit%0d", i));
      tick();
    end
    probe(P_MISO, 32'd0, "miso_after_last");
    probe(P_FLAG, 32'd0, "flag_clear_after_read");
    tx_valid = 1'b1; tx_data = 8'hFF;
    tick();
    probe(P_MISO, 32'd0, "miso_no_relatch");
    tx_valid = 1'b0;
    end_frame();

    // SS_n rises on the very edge that would sample bit 0.
    abort_frame(10'h2AA, 9);
    probe(P_FLAG, 32'd0, "abort_bit0_flag");

    // Reset while MISO shows bit 3.
    send_frame(10'h211);
    tick();
    end_frame();
    send_frame(10'h300);
    txv = 8'h5A;
    tx_valid = 1'b1; tx_data = txv;
    tick();
    tx_valid = 1'b0;
    for (int i = 7; i >= 3; i--) begin
      probe(P_MISO, 32'(txv[i]), $sformatf("miso_5a_bit%0d", i));
      if (i > 3) tick();
    end
    probe(P_FLAG, 32'd1, "flag_during_read");
    rst_n = 1'b0;
    tick();
    probe(P_MISO, 32'd0, "midread_reset_miso");
    probe(P_STATE, 32'(IDLE), "midread_reset_state");
    probe(P_FLAG, 32'd0, "midread_reset_flag");
    probe(P_RXD, 32'd0, "midread_reset_rx_data");
    rst_n = 1'b1;

    // SS_n already low: the first edge out of reset must start the frame.
    send_frame(10'h0C3);
    tick();
    end_frame();
    probe(P_END, 32'd0, "end");
    tick();
    tick();
  end

endmodule
